rob_multiport: RTL

Parametrised reorder buffer: depth, result-bus port count and field widths are configurable. It takes up to one in-order allocation per cycle from rename and accepts out-of-order results from `CDB_PORTS` common-data-bus broadcasts. It retires at most one instruction per cycle in program order onto a registered commit bus. When a redirecting control-flow instruction commits, the buffer flushes itself, and downstream commit back-pressure is supported.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_multiport_if.sv | 48 ++++
 rtl/rob_status_table.sv | 37 +++
 rtl/rob_multiport.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared constants and the default-width entry layout for the reorder buffer.
package rob_pkg;
  localparam int XLEN    = 32;
  localparam int CTRL_W  = 5;
  localparam int INDEX_W = 8;

  localparam int REDIRECT_BIT  = 0;
  localparam int INFO_REGWRITE = 3;
  localparam int INFO_MEMWRITE = 2;
  localparam int INFO_JUMP     = 1;
  localparam int INFO_BRANCH   = 0;

  typedef struct packed {
    logic [XLEN-1:0]    dest;
    logic [3:0]         info;
    logic [XLEN-1:0]    pc;
    logic [INDEX_W-1:0] pht;
    logic [XLEN-1:0]    snap;
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    target;
    logic [CTRL_W:0]    ctrl;   // {isControl, pcControl}
  } rob_entry_t;
endpackage

// File: rtl/rob_multiport_if.sv
// Rename, CDB and commit-side signals of the reorder buffer in one bundle.
interface rob_multiport_if #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2,
  parameter int CTRL_W    = 5,
  parameter int INDEX_W   = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                              allocValid, allocReady;
  logic [XLEN-1:0]                   allocDest, allocPC, allocRegStatus;
  logic [3:0]                        allocCommitInfo;
  logic [INDEX_W-1:0]                allocPHTIndex;
  logic [PTR_W-1:0]                  allocTag;

  logic [CDB_PORTS-1:0]              cdbValid, cdbIsControl;
  logic [CDB_PORTS-1:0][PTR_W-1:0]   cdbTag;
  logic [CDB_PORTS-1:0][XLEN-1:0]    cdbResult, cdbTarget;
  logic [CDB_PORTS-1:0][CTRL_W-1:0]  cdbPcControl;

  logic                              commitStall, commitValid;
  logic [PTR_W-1:0]                  commitTag;
  logic [XLEN-1:0]                   commitResult, commitTarget, commitPC;
  logic [XLEN-1:0]                   commitStatusSnap, commitDest;
  logic [CTRL_W:0]                   commitControlFlow;
  logic [3:0]                        commitInfo;
  logic [INDEX_W-1:0]                commitPHTIndex;

  logic [PTR_W:0]                    occupancy;
  logic                              empty, full;

  modport master (
    output allocValid, allocDest, allocCommitInfo, allocPC, allocPHTIndex, allocRegStatus,
    output cdbValid, cdbTag, cdbResult, cdbTarget, cdbIsControl, cdbPcControl, commitStall,
    input  allocReady, allocTag, commitValid, commitTag, commitResult, commitTarget, commitPC,
    input  commitStatusSnap, commitDest, commitControlFlow, commitInfo, commitPHTIndex,
    input  occupancy, empty, full
  );

  modport slave (
    input  allocValid, allocDest, allocCommitInfo, allocPC, allocPHTIndex, allocRegStatus,
    input  cdbValid, cdbTag, cdbResult, cdbTarget, cdbIsControl, cdbPcControl, commitStall,
    output allocReady, allocTag, commitValid, commitTag, commitResult, commitTarget, commitPC,
    output commitStatusSnap, commitDest, commitControlFlow, commitInfo, commitPHTIndex,
    output occupancy, empty, full
  );
endinterface

// File: rtl/rob_status_table.sv
// Per-entry valid/ready bits: one allocate port, PORTS ready-set ports, one clear port, flush.
module rob_status_table #(
  parameter int DEPTH = 8,
  parameter int PORTS = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_en,
  input  logic [PTR_W-1:0]            alloc_idx,
  input  logic [PORTS-1:0]            set_en,
  input  logic [PORTS-1:0][PTR_W-1:0] set_idx,
  input  logic                        clr_en,
  input  logic [PTR_W-1:0]            clr_idx,
  output logic [DEPTH-1:0]            valid,
  output logic [DEPTH-1:0]            ready
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      ready <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++)
        if (set_en[p]) ready[set_idx[p]] <= 1'b1;
      // clear after set so a broadcast to the retiring head leaves no stale ready bit
      if (clr_en) begin
        valid[clr_idx] <= 1'b0;
        ready[clr_idx] <= 1'b0;
      end
      if (alloc_en) begin
        valid[alloc_idx] <= 1'b1;
        ready[alloc_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order alloc, multi-port CDB writeback, in-order registered commit with flush.
// Optional ROB_CDB_BYPASS_EN lets a broadcast to the head commit at the same edge.
module rob_multiport #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2,
  parameter int CTRL_W    = 5,
  parameter int INDEX_W   = 8
) (
  input logic          clk,
  input logic          globalReset,
  rob_multiport_if.slave bus
);
  import rob_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    dest;
    logic [3:0]         info;
    logic [XLEN-1:0]    pc;
    logic [INDEX_W-1:0] pht;
    logic [XLEN-1:0]    snap;
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    target;
    logic [CTRL_W:0]    ctrl;
  } slot_t;

  slot_t                slots [DEPTH];
  slot_t                head_slot;
  logic [PTR_W-1:0]     head, tail;
  logic [PTR_W:0]       count;
  logic [DEPTH-1:0]     ent_valid, ent_ready;
  logic [CDB_PORTS-1:0] set_en;
  logic                 full, alloc_fire, head_rdy, commit_fire, redirect;

  assign full           = (count == (PTR_W+1)'(DEPTH));
  assign alloc_fire     = bus.allocValid & ~full;
  assign bus.allocReady = ~full;
  assign bus.allocTag   = tail;
  assign bus.occupancy  = count;
  assign bus.empty      = (count == '0);
  assign bus.full       = full;

  always_comb begin
    head_slot = slots[head];
    head_rdy  = ent_valid[head] & ent_ready[head];
`ifdef ROB_CDB_BYPASS_EN
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (bus.cdbValid[p] && bus.cdbTag[p] == head && ent_valid[head] && !head_rdy) begin
        head_slot.result = bus.cdbResult[p];
        if (bus.cdbIsControl[p]) begin
          head_slot.target = bus.cdbTarget[p];
          head_slot.ctrl   = {1'b1, bus.cdbPcControl[p]};
        end
        head_rdy = 1'b1;
      end
    end
`endif
  end

  assign commit_fire = (count != '0) & head_rdy & ~bus.commitStall;
  assign redirect    = commit_fire & head_slot.ctrl[REDIRECT_BIT];

  always_comb begin
    set_en = '0;
    for (int p = 0; p < CDB_PORTS; p++)
      set_en[p] = bus.cdbValid[p] & ent_valid[bus.cdbTag[p]] & ~redirect;
  end

  rob_status_table #(.DEPTH(DEPTH), .PORTS(CDB_PORTS), .PTR_W(PTR_W)) u_status (
    .clk(clk), .rst(globalReset), .flush(redirect),
    .alloc_en(alloc_fire), .alloc_idx(tail),
    .set_en(set_en), .set_idx(bus.cdbTag),
    .clr_en(commit_fire), .clr_idx(head),
    .valid(ent_valid), .ready(ent_ready)
  );

  always_ff @(posedge clk) begin
    if (globalReset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= head + PTR_W'(1);
      tail  <= head + PTR_W'(1);
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + PTR_W'(1);
      if (commit_fire) head <= head + PTR_W'(1);
      if (alloc_fire && !commit_fire)      count <= count + (PTR_W+1)'(1);
      else if (!alloc_fire && commit_fire) count <= count - (PTR_W+1)'(1);
    end
  end

  // Payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      slots[tail].dest   <= bus.allocDest;
      slots[tail].info   <= bus.allocCommitInfo;
      slots[tail].pc     <= bus.allocPC;
      slots[tail].pht    <= bus.allocPHTIndex;
      slots[tail].snap   <= bus.allocRegStatus;
      slots[tail].result <= '0;
      slots[tail].target <= '0;
      slots[tail].ctrl   <= '0;
    end
    // descending loop: the lowest-indexed port's write lands last and wins
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (set_en[p]) begin
        slots[bus.cdbTag[p]].result <= bus.cdbResult[p];
        if (bus.cdbIsControl[p]) begin
          slots[bus.cdbTag[p]].target <= bus.cdbTarget[p];
          slots[bus.cdbTag[p]].ctrl   <= {1'b1, bus.cdbPcControl[p]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (globalReset) begin
      bus.commitValid       <= 1'b0;
      bus.commitTag         <= '0;
      bus.commitResult      <= '0;
      bus.commitTarget      <= '0;
      bus.commitPC          <= '0;
      bus.commitStatusSnap  <= '0;
      bus.commitDest        <= '0;
      bus.commitControlFlow <= '0;
      bus.commitInfo        <= '0;
      bus.commitPHTIndex    <= '0;
    end else if (commit_fire) begin
      bus.commitValid       <= 1'b1;
      bus.commitTag         <= head;
      bus.commitResult      <= head_slot.result;
      bus.commitTarget      <= head_slot.target;
      bus.commitPC          <= head_slot.pc;
      bus.commitStatusSnap  <= head_slot.snap;
      bus.commitDest        <= head_slot.dest;
      bus.commitControlFlow <= head_slot.ctrl;
      bus.commitInfo        <= head_slot.info;
      bus.commitPHTIndex    <= head_slot.pht;
    end else begin
      bus.commitValid       <= 1'b0;
      bus.commitControlFlow <= '0;
      bus.commitInfo        <= '0;
    end
  end
endmodule
